fft_bitrev_reader: RTL and testbench

- Read-side sequencer for the 32-point sample buffer.
- The write side fills the buffer in natural order using a 5-bit counter; its carry-out marks the buffer as full.
- On each start, this block issues one read per buffer location, in bit-reversed address order. It then delivers the samples on a valid/ready stream to the first butterfly stage.
- It absorbs the buffer's 1-cycle read latency and downstream backpressure with a 2-entry output queue.

---
 rtl/fft_bitrev_reader_if.sv | 27 ++
 rtl/fft_bitrev_reader.sv | 87 ++++++++
 tb/tb_fft_bitrev_reader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reader_if.sv
// fft_bitrev_reader_if: buffer read port plus output sample stream of the frame reader
// Signals:
//   rd_en/rd_addr  read strobe and address toward the sample buffer
//   rd_data        buffer read data, valid one cycle after rd_en
//   out_valid/out_ready/out_data/out_index/out_last  sample stream to the butterfly stage
// master = reader side, slave = buffer + downstream side.
interface fft_bitrev_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_index, out_last,
        input  rd_data, out_ready
    );
    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_index, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/fft_bitrev_reader.sv
// fft_bitrev_reader: reads one 2**ADDR_W-sample frame in bit-reversed address order and streams it out
// Ports: clk, sclr (sync active-high reset), start (frame request, IDLE only),
//   busy (RUN/DRAIN), done (one-cycle pulse after final transfer),
//   bus (fft_bitrev_reader_if.master: buffer read port + valid/ready sample stream).
// Build option: FFT_BITREV_EN defined -> rd_addr = bitrev(idx); undefined -> rd_addr = idx.
module fft_bitrev_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       sclr,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    fft_bitrev_reader_if.master        bus
);
    localparam int N = 2 ** ADDR_W;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    logic [1:0]        state;
    logic [ADDR_W:0]   idx;
    logic              inflight;
    logic [ADDR_W-1:0] cap_idx;
    logic [1:0]        occ;
    logic [DATA_W-1:0] q_data [2];
    logic [ADDR_W-1:0] q_idx  [2];
    logic              pop;
    logic              last_rd;
    logic              fin;
    logic              slot;
    logic [ADDR_W-1:0] addr;
    assign pop       = bus.out_valid && bus.out_ready;
    // a read is only issued if its data is guaranteed a queue slot on arrival
    assign bus.rd_en = state == RUN && (3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2;
    assign last_rd   = bus.rd_en && idx == (ADDR_W+1)'(N-1);
    assign fin       = state == DRAIN && !inflight && occ == 2'd1 && pop;
    // arriving data lands in entry 1 only if one sample remains after this cycle's pop
    assign slot      = occ == 2'd2 || (occ == 2'd1 && !pop);
`ifdef FFT_BITREV_EN
    always_comb begin
        addr = '0;
        for (int i = 0; i < ADDR_W; i++) addr[i] = idx[ADDR_W-1-i];
    end
`else
    assign addr = idx[ADDR_W-1:0];
`endif
    assign bus.rd_addr   = addr;
    assign bus.out_valid = occ != 2'd0;
    assign bus.out_data  = q_data[0];
    assign bus.out_index = q_idx[0];
    assign bus.out_last  = bus.out_valid && q_idx[0] == ADDR_W'(N-1);
    assign busy          = state != IDLE;
    always_ff @(posedge clk) begin
        if (sclr) begin
            state    <= IDLE;
            idx      <= '0;
            inflight <= 1'b0;
            cap_idx  <= '0;
            occ      <= '0;
            done     <= 1'b0;
            q_data   <= '{default: '0};
            q_idx    <= '{default: '0};
        end else begin
            inflight <= bus.rd_en;
            done     <= fin;
            occ      <= occ + 2'(inflight) - 2'(pop);
            if (bus.rd_en) begin
                idx     <= idx + (ADDR_W+1)'(1);
                cap_idx <= idx[ADDR_W-1:0];
            end
            if (pop) begin
                q_data[0] <= q_data[1];
                q_idx[0]  <= q_idx[1];
            end
            if (inflight) begin
                q_data[slot] <= bus.rd_data;
                q_idx[slot]  <= cap_idx;
            end
            // done is still high on the first IDLE cycle, which keeps that start ignored
            if (state == IDLE && start && !done) idx <= '0;
            state <= (state == IDLE && start && !done) ? RUN :
                     last_rd ? DRAIN :
                     fin ? IDLE : state;
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reader.sv
// tb_fft_bitrev_reader: table-driven and randomized frame checks against a scoreboard of expected samples
module tb_fft_bitrev_reader;
    typedef struct {
        bit ramp;
        bit rnd;
        int lo;
        int hi;
        int sa;
        int sb;
        int abort_at;
        int exp_done;
    } vec_t;
    logic clk = 1'b0;
    logic sclr;
    logic start;
    logic busy;
    logic done;
    logic [31:0] mem [32];
    int passed = 0;
    int total = 0;
    logic s_valid, s_rd_en, s_last, s_busy, s_done;
    logic [4:0] s_addr, s_idx;
    logic [31:0] s_data;
    vec_t tbl [8];
    fft_bitrev_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();
    fft_bitrev_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk),
        .sclr(sclr),
        .start(start),
        .busy(busy),
        .done(done),
        .bus(bus.master)
    );
    always #5 clk = ~clk;
    function automatic int ref_addr(input int i);
`ifdef FFT_BITREV_EN
        int r = 0;
        for (int b = 0; b < 5; b++) if ((i & (1 << b)) != 0) r += 16 >> b;
        return r;
`else
        return i;
`endif
    endfunction
    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask
    task automatic step(input bit st, input bit rdy, input bit rs);
        start = st;
        bus.out_ready = rdy;
        sclr = rs;
        #1;
        s_valid = bus.out_valid;
        s_rd_en = bus.rd_en;
        s_addr  = bus.rd_addr;
        s_data  = bus.out_data;
        s_idx   = bus.out_index;
        s_last  = bus.out_last;
        s_busy  = busy;
        s_done  = done;
        @(posedge clk);
        #1;
        bus.rd_data = s_rd_en ? mem[s_addr] : $urandom;
    endtask
    task automatic run_frame(input vec_t v);
        int reads = 0;
        int xfers = 0;
        int dones = 0;
        int c = 0;
        int rd_cyc [32];
        bit stall = 1'b0;
        bit rdy;
        logic [31:0] held_d = '0;
        logic [4:0] held_i = '0;
        for (int k = 0; k < 32; k++) mem[k] = v.ramp ? 32'(k) : $urandom;
        step(1'b1, 1'b1, 1'b0);
        check("idle_rd_en", s_rd_en, 0);
        check("idle_busy", s_busy, 0);
        while (1) begin
            c++;
            if (c > 300) begin
                check("frame_timeout", dones, 1);
                break;
            end
            rdy = v.rnd ? 1'($urandom_range(0, 1)) : !(c >= v.lo && c <= v.hi);
            if (v.abort_at >= 0 && xfers == v.abort_at) begin
                step(1'b0, rdy, 1'b1);
                step(1'b0, 1'b1, 1'b0);
                check("abort_valid", s_valid, 0);
                check("abort_busy", s_busy, 0);
                check("abort_rd_en", s_rd_en, 0);
                check("abort_done", s_done, 0);
                check("abort_index", s_idx, 0);
                check("abort_data", s_data, 0);
                return;
            end
            step(c == v.sa || c == v.sb, rdy, 1'b0);
            check("outstanding_le2", (reads - xfers) <= 2, 1);
            if (stall) begin
                check("hold_valid", s_valid, 1);
                check("hold_data", s_data, held_d);
                check("hold_index", s_idx, held_i);
            end
            if (s_rd_en) begin
                check("rd_count", reads < 32, 1);
                if (reads < 32) begin
                    check("rd_addr", s_addr, ref_addr(reads));
                    rd_cyc[reads] = c;
                end
                reads++;
            end
            if (s_valid && rdy) begin
                check("out_index", s_idx, xfers);
                check("out_data", s_data, mem[ref_addr(xfers % 32)]);
                check("out_last", s_last, xfers == 31);
                if (!v.rnd && v.lo < 0 && xfers < reads) check("latency", c, rd_cyc[xfers] + 2);
                xfers++;
            end
            stall = s_valid && !rdy;
            held_d = s_data;
            held_i = s_idx;
            if (s_done) begin
                dones++;
                check("done_xfers", xfers, 32);
                check("done_reads", reads, 32);
                check("done_busy", s_busy, 0);
                if (v.exp_done > 0) check("done_cycle", c, v.exp_done);
                break;
            end
            check("busy", s_busy, 1);
        end
    endtask
    initial begin
        start = 1'b0;
        sclr = 1'b1;
        bus.out_ready = 1'b0;
        bus.rd_data = '0;
        for (int k = 0; k < 32; k++) mem[k] = 32'(k);
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("rst_rd_en", s_rd_en, 0);
        check("rst_rd_addr", s_addr, 0);
        check("rst_out_valid", s_valid, 0);
        check("rst_out_data", s_data, 0);
        check("rst_out_index", s_idx, 0);
        check("rst_out_last", s_last, 0);
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0);
            check("idle_no_read", s_rd_en, 0);
        end
        tbl[0] = '{1'b1, 1'b0, -1, -1, -1, -1, -1, 35};
        tbl[1] = '{1'b1, 1'b0, 3, 12, -1, -1, -1, 45};
        tbl[2] = '{1'b0, 1'b0, -1, -1, 5, 20, -1, 35};
        tbl[3] = '{1'b1, 1'b0, -1, -1, 35, -1, -1, 35};
        tbl[4] = '{1'b0, 1'b0, -1, -1, -1, -1, -1, 35};
        tbl[5] = '{1'b1, 1'b0, -1, -1, -1, -1, 10, 0};
        tbl[6] = '{1'b1, 1'b0, -1, -1, -1, -1, -1, 35};
        tbl[7] = '{1'b0, 1'b1, -1, -1, -1, -1, -1, 0};
        for (int r = 0; r < 8; r++) run_frame(tbl[r]);
        for (int r = 0; r < 4; r++) run_frame('{1'b0, 1'b1, -1, -1, -1, -1, -1, 0});
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
